// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, keeps one instruction-memory request in flight, and feeds the IF/ID register.
// Define FETCH_MISALIGN_EN to add fetch_misalign_o and a HALT state for misaligned redirects.
`timescale 1ns/1ps
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic [6:0]      opcode_o
`ifdef FETCH_MISALIGN_EN
    ,
    output logic            fetch_misalign_o
`endif
);

    localparam logic [2:0] S_REQ  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_DROP = 3'd3;
`ifdef FETCH_MISALIGN_EN
    localparam logic [2:0] S_HALT = 3'd4;
`endif

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_inc;
    logic [XLEN-1:0] w_redir_pc;
    logic            r_req;
    logic            w_accept;
    logic            w_load;
    logic [XLEN-1:0] w_load_instr;
    logic            w_buf_we;
    logic [XLEN-1:0] r_buf_instr;
    logic            r_ifid_valid;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_instr;

    // r_req is low through reset and its first cycle, so a REQ state alone is not a live request.
    assign w_accept = r_req & imem_ready_i;
    assign w_pc_inc = r_pc + XLEN'(4);

`ifdef FETCH_MISALIGN_EN
    logic w_misalign;
    logic r_misalign;
    assign w_misalign = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    assign w_redir_pc = redirect_pc_i;
`else
    assign w_redir_pc = redirect_pc_i & ~XLEN'(3);
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_load       = 1'b0;
        w_load_instr = imem_rdata_i;
        w_buf_we     = 1'b0;
        case (r_state)
            S_REQ: begin
                if (redirect_i) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = w_accept ? S_DROP : S_REQ;
                end else if (w_accept) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = imem_rvalid_i ? S_REQ : S_DROP;
                end else if (imem_rvalid_i) begin
                    if (stall_i) begin
                        w_buf_we    = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_load      = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_REQ;
                end else if (!stall_i) begin
                    w_load       = 1'b1;
                    w_load_instr = r_buf_instr;
                    w_pc_nxt     = w_pc_inc;
                    w_state_nxt  = S_REQ;
                end
            end
            S_DROP: begin
                // A redirect that coincides with the dropped response must not wait for a second one.
                if (redirect_i) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = imem_rvalid_i ? S_REQ : S_DROP;
                end else if (imem_rvalid_i) begin
                    w_state_nxt = S_REQ;
                end
            end
`ifdef FETCH_MISALIGN_EN
            S_HALT: begin
                if (redirect_i) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_REQ;
                end
            end
`endif
            default: w_state_nxt = S_REQ;
        endcase
`ifdef FETCH_MISALIGN_EN
        if (w_misalign) begin
            w_state_nxt = S_HALT;
            w_pc_nxt    = r_pc;
            w_load      = 1'b0;
            w_buf_we    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_req       <= 1'b0;
            r_buf_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_req   <= (w_state_nxt == S_REQ);
            if (w_buf_we) begin
                r_buf_instr <= imem_rdata_i;
            end
        end
    end

    // IF/ID register: flush beats hold, hold beats load, and anything else is a bubble.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
        end else if (redirect_i) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
        end else if (stall_i) begin
            r_ifid_valid <= r_ifid_valid;
        end else if (w_load) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= w_load_instr;
        end else begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
        end
    end

`ifdef FETCH_MISALIGN_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
        end
    end
    assign fetch_misalign_o = r_misalign;
`endif

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_pc;
    assign if_id_valid_o = r_ifid_valid;
    assign if_id_pc_o    = r_ifid_pc;
    assign if_id_instr_o = r_ifid_instr;
    assign opcode_o      = r_ifid_instr[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a memory/branch model predicts delivered instructions into a scoreboard.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [6:0]  opcode;
`ifdef FETCH_MISALIGN_EN
    logic        misalign;
`endif

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ready_i  (imem_ready),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .if_id_valid_o (ifid_valid),
        .if_id_pc_o    (ifid_pc),
        .if_id_instr_o (ifid_instr),
        .opcode_o      (opcode)
`ifdef FETCH_MISALIGN_EN
        ,
        .fetch_misalign_o (misalign)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Transaction-level model state
    bit          outst;
    bit          out_killed;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    int          wcnt;
    bit          pend;
    logic [31:0] pend_pc;
    logic [31:0] pend_instr;
    logic [31:0] exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        outst  = 0;
        pend   = 0;
        exp_pc = 32'h0;
        sb.delete();
    endtask

    // One clock of stimulus: memory responds, branch/stall inputs are applied, the model advances.
    task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
        bit   acc_now;
        bit   mis;
        ent_t e;
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = tgt;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        acc_now     = 0;
        if (outst) begin
            chk("one_outstanding_req", {31'b0, imem_req}, 32'h0);
            if (wcnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = out_instr;
            end else begin
                wcnt--;
            end
        end else if (imem_req && ($urandom_range(0, 2) != 0)) begin
            imem_ready = 1'b1;
            chk("fetch_addr", imem_addr, exp_pc);
            out_pc     = exp_pc;
            out_instr  = $urandom;
            out_killed = 0;
            wcnt       = $urandom_range(0, 2);
            acc_now    = 1;
        end
        mis = 0;
`ifdef FETCH_MISALIGN_EN
        mis = rd && (tgt[1:0] != 2'b00);
`endif
        if (imem_rvalid) begin
            outst = 0;
            if (!out_killed && !rd) begin
                pend       = 1;
                pend_pc    = out_pc;
                pend_instr = out_instr;
            end
        end
        if (pend) begin
            if (rd) begin
                pend = 0;
            end else if (!st) begin
                e.pc    = pend_pc;
                e.instr = pend_instr;
                sb.push_back(e);
                exp_pc = pend_pc + 32'd4;
                pend   = 0;
            end
        end
        if (acc_now) outst = 1;
        if (rd) begin
            if (outst) out_killed = 1;
            if (!mis) exp_pc = tgt & ~32'h3;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((outst || pend) && n < 50) begin
            step(0, 0, 32'h0);
            n++;
        end
        if (outst || pend) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout cycles=%0d outstanding=%0d pending=%0d", n, outst, pend);
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = 32'h0000_0100;
            1:       t = 32'hFFFF_FFF8;
            2:       t = 32'hFFFF_FFFC;
            default: t = $urandom;
        endcase
`ifdef FETCH_MISALIGN_EN
        t = t & ~32'h3;
`endif
        return t;
    endfunction

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 11) == 0, pick_target());
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_valid"}, {31'b0, ifid_valid}, 32'h0);
        chk({tag, "_pc"}, ifid_pc, 32'h0);
        chk({tag, "_instr"}, ifid_instr, NOP);
        chk({tag, "_opcode"}, {25'b0, opcode}, 32'h13);
`ifdef FETCH_MISALIGN_EN
        chk({tag, "_misalign"}, {31'b0, misalign}, 32'h0);
`endif
    endtask

    // Monitor: compares every IF/ID presentation against the scoreboard.
    initial begin
        bit   prev_valid = 0;
        ent_t last = '0;
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 0;
                continue;
            end
            if (redirect) begin
                chk("flush_valid", {31'b0, ifid_valid}, 32'h0);
                chk("flush_instr", ifid_instr, NOP);
            end else if (stall && prev_valid) begin
                chk("hold_valid", {31'b0, ifid_valid}, 32'h1);
                chk("hold_pc", ifid_pc, last.pc);
                chk("hold_instr", ifid_instr, last.instr);
            end else if (ifid_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ifid_valid", {31'b0, ifid_valid}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("ifid_pc", ifid_pc, e.pc);
                    chk("ifid_instr", ifid_instr, e.instr);
                    chk("opcode", {25'b0, opcode}, {25'b0, e.instr[6:0]});
                    last = e;
                end
            end else begin
                chk("bubble_instr", ifid_instr, NOP);
                chk("missed_load", sb.size(), 32'h0);
            end
            prev_valid = ifid_valid;
        end
    end

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);

        // Clean straight-line fetch, then randomized traffic.
        repeat (12) step(0, 0, 32'h0);
        random_phase(1500);

        // Address wrap at the top of the address space.
        drain();
        step(0, 1, 32'hFFFF_FFF8);
        repeat (16) step(0, 0, 32'h0);

        // Reset in the middle of traffic.
        random_phase(7);
        @(negedge clk);
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        model_reset();
        #1;
        check_reset_values("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        random_phase(1500);

        drain();
`ifdef FETCH_MISALIGN_EN
        step(0, 1, 32'h0000_0102);
        @(posedge clk);
        #1;
        chk("misalign_pulse", {31'b0, misalign}, 32'h1);
        chk("halt_req_0", {31'b0, imem_req}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 32'h0);
            @(posedge clk);
            #1;
            chk("misalign_once", {31'b0, misalign}, 32'h0);
            chk("halt_req", {31'b0, imem_req}, 32'h0);
            chk("halt_valid", {31'b0, ifid_valid}, 32'h0);
        end
        step(0, 1, 32'h0000_0200);
`else
        step(0, 1, 32'h0000_0102);
`endif
        repeat (16) step(0, 0, 32'h0);
        drain();
        repeat (3) step(0, 0, 32'h0);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
